// File: rtl/clkgen_pkg.sv
// Shared constants and helpers for the clock-enable generator.
// Defaults for counter width and test shift, channel-index width helper.
package clkgen_pkg;

  localparam int CNT_W_DEF     = 27;
  localparam int TST_SHIFT_DEF = 16;
  localparam int DIV_MIN       = 1;
  localparam int NUM_CH_MAX    = 16;

  // Width of a channel index; at least one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One tick channel: divisor register, effective-divisor calc, counter, tick flop.
// Ports:
//   clk, rst       master clock, synchronous active-high reset
//   tst            shorten divisor by TST_SHIFT
//   pause          hold counter, force tick low
//   sync           zero counter, force tick low
//   load/load_val  replace divisor on this edge (caller gates to wrap/sync)
//   wrap           this edge ends a period (combinational)
//   tick           registered one-cycle enable
//   wave           toggle output, only with CLKGEN_TOGGLE_OUT_EN defined
module clk_div_chan
  import clkgen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TST_SHIFT = TST_SHIFT_DEF,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(100)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tst,
  input  logic             pause,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             wrap,
`ifdef CLKGEN_TOGGLE_OUT_EN
  output logic             wave,
`endif
  output logic             tick
);

  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] shr;
  logic [CNT_W-1:0] eff;
  logic             hit;

  assign shr = tst ? (div_q >> TST_SHIFT) : div_q;
  assign eff = (shr == '0) ? CNT_W'(DIV_MIN) : shr;

  // >= rather than == so a divisor that shrinks mid-count
  // (tst rising) wraps on the next edge instead of running long.
  assign hit  = cnt_q >= (eff - CNT_W'(1));
  assign wrap = ~pause & ~sync & hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DIV_RST;
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      if (load) begin
        div_q <= load_val;
      end
      if (sync) begin
        cnt_q <= '0;
        tick  <= 1'b0;
      end else if (pause) begin
        tick  <= 1'b0;
      end else if (hit) begin
        cnt_q <= '0;
        tick  <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
        tick  <= 1'b0;
      end
    end
  end

`ifdef CLKGEN_TOGGLE_OUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wave <= 1'b0;
    end else if (sync) begin
      wave <= 1'b0;
    end else if (wrap) begin
      wave <= ~wave;
    end
  end
`endif

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator with per-channel run-time divisors.
// Optional toggle outputs when CLKGEN_TOGGLE_OUT_EN is defined.
// Ports:
//   clk, rst             master clock, synchronous active-high reset
//   tst, pause, sync     test acceleration, freeze, phase align (all channels)
//   cfg_valid/cfg_ready  divisor update handshake
//   cfg_ch, cfg_div      target channel and new divisor (0 acts as 1)
//   tick[NUM_CH]         registered one-cycle enables
//   wave[NUM_CH]         50% toggle per channel (CLKGEN_TOGGLE_OUT_EN only)
module clk_enable_gen
  import clkgen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT =
    {NUM_CH{CNT_W'(100)}},
  parameter int TST_SHIFT = TST_SHIFT_DEF,
  localparam int CH_W = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tst,
  input  logic              pause,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
`ifdef CLKGEN_TOGGLE_OUT_EN
  output logic [NUM_CH-1:0] wave,
`endif
  output logic [NUM_CH-1:0] tick
);

  logic              rst_q;
  logic              pend_q;
  logic [CH_W-1:0]   pend_ch_q;
  logic [CNT_W-1:0]  pend_div_q;

  logic              accept;
  logic              in_rng;
  logic              src_vld;
  logic [CH_W-1:0]   src_ch;
  logic [CNT_W-1:0]  src_div;
  logic              applied;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] load;

  assign cfg_ready = ~rst_q & ~pend_q;
  assign accept    = cfg_valid & cfg_ready;
  assign in_rng    = int'(cfg_ch) < NUM_CH;

  // The pending entry and a fresh accept never coexist (ready
  // drops while pending), so one source mux feeds all channels.
  // A fresh accept may land directly if its channel wraps or
  // sync fires on the accepting edge.
  assign src_vld = pend_q | (accept & in_rng);
  assign src_ch  = pend_q ? pend_ch_q : cfg_ch;
  assign src_div = pend_q ? pend_div_q : cfg_div;
  assign applied = |load;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load[i] = src_vld
                   & (src_ch == CH_W'(i))
                   & (sync | wrap[i]);

    clk_div_chan #(
      .CNT_W     (CNT_W),
      .TST_SHIFT (TST_SHIFT),
      .DIV_RST   (DIV_INIT[i*CNT_W +: CNT_W])
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .tst      (tst),
      .pause    (pause),
      .sync     (sync),
      .load     (load[i]),
      .load_val (src_div),
      .wrap     (wrap[i]),
`ifdef CLKGEN_TOGGLE_OUT_EN
      .wave     (wave[i]),
`endif
      .tick     (tick[i])
    );
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      pend_q     <= 1'b0;
      pend_ch_q  <= '0;
      pend_div_q <= '0;
    end else if (pend_q) begin
      if (applied) begin
        pend_q <= 1'b0;
      end
    end else if (accept & in_rng & ~applied) begin
      pend_q     <= 1'b1;
      pend_ch_q  <= cfg_ch;
      pend_div_q <= cfg_div;
    end
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Bench for clk_enable_gen: directed scenarios plus random traffic,
// all outputs compared every cycle against a behavioural model.
module tb_clk_enable_gen;

  localparam int N  = 4;
  localparam int W  = 27;
  localparam int SH = 4;
  localparam logic [N*W-1:0] INIT =
    {27'd1, 27'd2, 27'd3, 27'd4};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tst = 1'b0;
  logic         pause = 1'b0;
  logic         sync = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [1:0]   cfg_ch = '0;
  logic [W-1:0] cfg_div = '0;
  logic [N-1:0] tick;
`ifdef CLKGEN_TOGGLE_OUT_EN
  logic [N-1:0] wave;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_enable_gen #(
    .NUM_CH    (N),
    .CNT_W     (W),
    .DIV_INIT  (INIT),
    .TST_SHIFT (SH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tst       (tst),
    .pause     (pause),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
`ifdef CLKGEN_TOGGLE_OUT_EN
    .wave      (wave),
`endif
    .tick      (tick)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    int ch;
    int dv;
  } upd_t;

  upd_t pq[$];
  int   m_ph[N];
  int   m_dv[N];
  bit   m_tk[N];
  bit   m_wv[N];
  bit   m_rstq = 1'b1;
  bit   mvalid = 1'b0;
  int   cyc = 0;

  function automatic int init_div(input int c);
    return int'(INIT[c*W +: W]);
  endfunction

  function automatic int eff(input int d, input bit t);
    int e;
    e = t ? (d >> SH) : d;
    return (e < 1) ? 1 : e;
  endfunction

  always @(posedge clk) begin
    bit   rdy;
    bit   wr;
    upd_t u;
    cyc++;
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        m_ph[c] = 0;
        m_dv[c] = init_div(c);
        m_tk[c] = 1'b0;
        m_wv[c] = 1'b0;
      end
      pq.delete();
      m_rstq = 1'b1;
      mvalid = 1'b1;
    end else begin
      rdy = !m_rstq && (pq.size() == 0);
      if (cfg_valid && rdy && int'(cfg_ch) < N) begin
        u.ch = int'(cfg_ch);
        u.dv = int'(cfg_div);
        pq.push_back(u);
      end
      for (int c = 0; c < N; c++) begin
        wr = !pause && !sync
          && (m_ph[c] >= eff(m_dv[c], tst) - 1);
        if (sync) begin
          m_ph[c] = 0;
          m_tk[c] = 1'b0;
          m_wv[c] = 1'b0;
        end else if (pause) begin
          m_tk[c] = 1'b0;
        end else if (wr) begin
          m_ph[c] = 0;
          m_tk[c] = 1'b1;
          m_wv[c] = !m_wv[c];
        end else begin
          m_ph[c] = m_ph[c] + 1;
          m_tk[c] = 1'b0;
        end
        if (pq.size() > 0 && pq[0].ch == c
            && (sync || wr)) begin
          m_dv[c] = pq[0].dv;
          pq.delete(0);
        end
      end
      m_rstq = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit er;
    if (mvalid) begin
      for (int c = 0; c < N; c++) begin
        checks++;
        if (tick[c] !== m_tk[c]) begin
          errors++;
          $display("FAIL tick[%0d] cyc %0d: got %b want %b",
                   c, cyc, tick[c], m_tk[c]);
        end
`ifdef CLKGEN_TOGGLE_OUT_EN
        checks++;
        if (wave[c] !== m_wv[c]) begin
          errors++;
          $display("FAIL wave[%0d] cyc %0d: got %b want %b",
                   c, cyc, wave[c], m_wv[c]);
        end
`endif
      end
      er = !m_rstq && (pq.size() == 0);
      checks++;
      if (cfg_ready !== er) begin
        errors++;
        $display("FAIL cfg_ready cyc %0d: got %b want %b",
                 cyc, cfg_ready, er);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_tick(input int c, input int budget,
                           output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tick[c]) begin
        at = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_tick[%0d]: none in %0d cycles",
             c, budget);
  endtask

  task automatic first_ticks(input int span,
                             output int f[N]);
    int r;
    r = cyc;
    for (int c = 0; c < N; c++) f[c] = -1;
    for (int k = 0; k < span; k++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++)
        if (tick[c] && f[c] < 0) f[c] = cyc - r;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int r0;
    int first0;
    int t0;
    int t1;
    int cnt[N];
    int f[N];
    int ones;
    bit seen;

    // reset and fixed-divisor run
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tick", int'(tick), 0);
    chk("rst_ready", int'(cfg_ready), 0);
    rst = 1'b0;
    r0 = cyc;
    first0 = -1;
    for (int c = 0; c < N; c++) cnt[c] = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++)
        if (tick[c]) cnt[c]++;
      if (tick[0] && first0 < 0) first0 = cyc - r0;
`ifdef CLKGEN_TOGGLE_OUT_EN
      if (k == 5) chk("wave0_e5", int'(wave[0]), 1);
      if (k == 8) chk("wave0_e8", int'(wave[0]), 0);
`endif
    end
    chk("t1_cnt_ch0", cnt[0], 6);
    chk("t1_cnt_ch1", cnt[1], 8);
    chk("t1_cnt_ch2", cnt[2], 12);
    chk("t1_cnt_ch3", cnt[3], 24);
    chk("t1_first_ch0", first0, 4);

    // divisor update mid-period on ch1 (div 3 -> 5)
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_ch = 2'd1;
    cfg_div = W'(5);
    chk("t3_ready_pre", int'(cfg_ready), 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("t3_ready_pend", int'(cfg_ready), 0);
    chk("t3_no_tick", int'(tick[1]), 0);
    @(negedge clk);
    chk("t3_wrap", int'(tick[1]), 1);
    chk("t3_ready_back", int'(cfg_ready), 1);
    t0 = cyc;
    chk("t3_p0_edge", t0 - r0, 27);
    wait_tick(1, 20, t1);
    chk("t3_p1", t1 - t0, 5);
    t0 = t1;
    wait_tick(1, 20, t1);
    chk("t3_p2", t1 - t0, 5);

    // pause at ch0 cnt=2
    wait_tick(0, 10, t0);
    @(negedge clk);
    @(negedge clk);
    pause = 1'b1;
    seen = 1'b0;
    repeat (7) begin
      @(negedge clk);
      seen |= |tick;
    end
    chk("t4_quiet", int'(seen), 0);
    pause = 1'b0;
    @(negedge clk);
    chk("t4_e1", int'(tick[0]), 0);
    @(negedge clk);
    chk("t4_e2", int'(tick[0]), 1);

    // test-mode acceleration on ch0 (div 20, shift 4)
    cfg_valid = 1'b1;
    cfg_ch = 2'd0;
    cfg_div = W'(20);
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int i = 0; i < 10 && !cfg_ready; i++)
      @(negedge clk);
    chk("t2_applied", int'(cfg_ready), 1);
    tst = 1'b1;
    ones = 0;
    repeat (6) begin
      @(negedge clk);
      if (tick[0]) ones++;
    end
    chk("t2_fast", ones, 6);
    tst = 1'b0;
    t0 = cyc;
    wait_tick(0, 40, t1);
    chk("t2_slow", t1 - t0, 20);
    repeat (10) @(negedge clk);
    tst = 1'b1;
    @(negedge clk);
    chk("t2_midcount_wrap", int'(tick[0]), 1);
    tst = 1'b0;

    // sync with an update pending on ch1 (5 -> 7)
    wait_tick(1, 20, t0);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_ch = 2'd1;
    cfg_div = W'(7);
    @(negedge clk);
    cfg_valid = 1'b0;
    sync = 1'b1;
    chk("t5_pend", int'(cfg_ready), 0);
    @(negedge clk);
    sync = 1'b0;
    chk("t5_sync_tick", int'(tick), 0);
    chk("t5_ready", int'(cfg_ready), 1);
    first_ticks(25, f);
    chk("t5_first_ch0", f[0], 20);
    chk("t5_first_ch1", f[1], 7);
    chk("t5_first_ch2", f[2], 2);
    chk("t5_first_ch3", f[3], 1);

    // reset with an update pending
    cfg_valid = 1'b1;
    cfg_ch = 2'd0;
    cfg_div = W'(9);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("t6_pend", int'(cfg_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_rst_tick", int'(tick), 0);
    chk("t6_rst_ready", int'(cfg_ready), 0);
`ifdef CLKGEN_TOGGLE_OUT_EN
    chk("t6_rst_wave", int'(wave), 0);
`endif
    rst = 1'b0;
    first_ticks(8, f);
    chk("t6_first_ch0", f[0], 4);
    chk("t6_first_ch1", f[1], 3);
    chk("t6_first_ch2", f[2], 2);
    chk("t6_first_ch3", f[3], 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      pause = ($urandom_range(0, 7) == 0);
      sync = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 39) == 0) tst = ~tst;
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch = 2'($urandom_range(0, 3));
      cfg_div = W'($urandom_range(0, 9));
    end
    @(negedge clk);
    rst = 1'b0;
    pause = 1'b0;
    sync = 1'b0;
    tst = 1'b0;
    cfg_valid = 1'b0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
